// File: rtl/wb_regfile.sv
// Writeback-stage architectural state: GPR file with same-cycle write bypass,
// HI/LO pair, LLbit, and a one-cycle-delayed commit trace for difftest.
module wb_regfile #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,

    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,

    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,

    input  logic              llbit_we,
    input  logic              llbit_value,
    input  logic              flush,
    output logic              llbit_o,

    input  logic [DATA_W-1:0] wb_pc,
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,

    output logic [31:0]       wr_cnt
);

    logic [DATA_W-1:0] r_gpr [REG_NUM];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_llbit;
    logic [DATA_W-1:0] r_tr_pc;
    logic [3:0]        r_tr_wen;
    logic [ADDR_W-1:0] r_tr_wnum;
    logic [DATA_W-1:0] r_tr_wdata;
    logic [31:0]       r_wr_cnt;

    // Writes to r0 are dropped entirely: no state change, no trace, no count.
    logic w_commit;
    assign w_commit = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_commit) begin
            r_gpr[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (whilo) begin
            r_hi <= hi_i;
            r_lo <= lo_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_llbit <= 1'b0;
        end else if (flush) begin
            r_llbit <= 1'b0;
        end else if (llbit_we) begin
            r_llbit <= llbit_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tr_pc    <= '0;
            r_tr_wen   <= '0;
            r_tr_wnum  <= '0;
            r_tr_wdata <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_tr_pc    <= wb_pc;
            r_tr_wen   <= {4{w_commit}};
            r_tr_wnum  <= waddr;
            r_tr_wdata <= wdata;
            if (w_commit) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    // Bypass lets decode see a WB write in the same cycle it commits.
    always_comb begin
        rdata1 = '0;
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (!re1) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (!re2) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_gpr[raddr2];
        end
    end

    always_comb begin
        llbit_o = r_llbit;
        if (flush) begin
            llbit_o = 1'b0;
        end else if (llbit_we) begin
            llbit_o = llbit_value;
        end
    end

    assign hi_o              = r_hi;
    assign lo_o              = r_lo;
    assign debug_wb_pc       = r_tr_pc;
    assign debug_wb_rf_wen   = r_tr_wen;
    assign debug_wb_rf_wnum  = r_tr_wnum;
    assign debug_wb_rf_wdata = r_tr_wdata;
    assign wr_cnt            = r_wr_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic against an
// array-based model of the committed architectural state.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        llbit_we;
    logic        llbit_value;
    logic        flush;
    logic        llbit_o;
    logic [31:0] wb_pc;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] wr_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo, m_cnt;
    logic        m_ll;
    logic [31:0] m_tr_pc, m_tr_wdata;
    logic [3:0]  m_tr_wen;
    logic [4:0]  m_tr_wnum;

    wb_regfile #(.REG_NUM(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o),
        .llbit_we(llbit_we), .llbit_value(llbit_value), .flush(flush), .llbit_o(llbit_o),
        .wb_pc(wb_pc), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_hi = '0; m_lo = '0; m_cnt = '0; m_ll = 1'b0;
        m_tr_pc = '0; m_tr_wen = '0; m_tr_wnum = '0; m_tr_wdata = '0;
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (!re) return 32'd0;
        if (we && waddr == ra) return wdata;
        return m_gpr[ra];
    endfunction

    function automatic logic exp_ll();
        if (flush) return 1'b0;
        if (llbit_we) return llbit_value;
        return m_ll;
    endfunction

    // Apply the architectural effect of the current inputs, then cross the edge.
    task automatic tick();
        if (rst) begin
            model_clear();
        end else begin
            if (we && waddr != 5'd0) begin
                m_gpr[waddr] = wdata;
                m_cnt = m_cnt + 32'd1;
            end
            if (whilo) begin m_hi = hi_i; m_lo = lo_i; end
            if (flush) m_ll = 1'b0;
            else if (llbit_we) m_ll = llbit_value;
            m_tr_pc    = wb_pc;
            m_tr_wen   = (we && waddr != 5'd0) ? 4'hF : 4'h0;
            m_tr_wnum  = waddr;
            m_tr_wdata = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        whilo = 0; hi_i = 0; lo_i = 0; llbit_we = 0; llbit_value = 0; flush = 0;
    endtask

    task automatic test_reset();
        re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd31;
        #1;
        n_checks++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL reset_read: rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
        end
        n_checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || llbit_o !== 1'b0 || wr_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_state: hi=%h lo=%h ll=%b cnt=%h expected 0", hi_o, lo_o, llbit_o, wr_cnt);
        end
        n_checks++;
        if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin
            n_err++; $display("FAIL reset_trace: pc=%h wen=%h wnum=%0d wdata=%h expected 0",
                              debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        logic [31:0] c0;
        we = 1; waddr = 5'd5; wdata = 32'h1234_5678;
        tick();
        we = 0; re1 = 1; raddr1 = 5'd5;
        #1;
        n_checks++;
        if (rdata1 !== 32'h1234_5678) begin
            n_err++; $display("FAIL wr_read: rdata1=%h expected 12345678", rdata1);
        end
        re1 = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'd0) begin
            n_err++; $display("FAIL wr_read_disabled: rdata1=%h expected 0", rdata1);
        end
        c0 = m_cnt;
        we = 1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; re2 = 1; raddr2 = 5'd0;
        #1;
        n_checks++;
        if (rdata2 !== 32'd0) begin
            n_err++; $display("FAIL r0_bypass: rdata2=%h expected 0", rdata2);
        end
        tick();
        we = 0;
        #1;
        n_checks++;
        if (rdata2 !== 32'd0 || wr_cnt !== c0) begin
            n_err++; $display("FAIL r0_write: rdata2=%h cnt=%0d expected 0 cnt=%0d", rdata2, wr_cnt, c0);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        we = 1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        re1 = 1; raddr1 = 5'd7; re2 = 1; raddr2 = 5'd7;
        #1;
        n_checks++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL bypass: rdata1=%h rdata2=%h expected deadbeef", rdata1, rdata2);
        end
        tick();
        we = 0; wdata = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL bypass_hold: rdata1=%h rdata2=%h expected deadbeef", rdata1, rdata2);
        end
        idle_inputs();
    endtask

    task automatic test_hilo();
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi; old_lo = m_lo;
        whilo = 1; hi_i = 32'hAAAA_0000; lo_i = 32'h0000_BBBB;
        #1;
        n_checks++;
        if (hi_o !== old_hi || lo_o !== old_lo) begin
            n_err++; $display("FAIL hilo_no_bypass: hi=%h lo=%h expected %h %h", hi_o, lo_o, old_hi, old_lo);
        end
        tick();
        whilo = 0; hi_i = 32'h1111_1111; lo_i = 32'h2222_2222;
        #1;
        n_checks++;
        if (hi_o !== 32'hAAAA_0000 || lo_o !== 32'h0000_BBBB) begin
            n_err++; $display("FAIL hilo_write: hi=%h lo=%h expected aaaa0000 0000bbbb", hi_o, lo_o);
        end
        tick();
        n_checks++;
        if (hi_o !== 32'hAAAA_0000 || lo_o !== 32'h0000_BBBB) begin
            n_err++; $display("FAIL hilo_hold: hi=%h lo=%h expected aaaa0000 0000bbbb", hi_o, lo_o);
        end
        idle_inputs();
    endtask

    task automatic test_llbit();
        llbit_we = 1; llbit_value = 1;
        #1;
        n_checks++;
        if (llbit_o !== 1'b1) begin
            n_err++; $display("FAIL ll_bypass: llbit_o=%b expected 1", llbit_o);
        end
        tick();
        llbit_we = 0; llbit_value = 0;
        #1;
        n_checks++;
        if (llbit_o !== 1'b1) begin
            n_err++; $display("FAIL ll_hold: llbit_o=%b expected 1", llbit_o);
        end
        flush = 1; llbit_we = 1; llbit_value = 1;
        #1;
        n_checks++;
        if (llbit_o !== 1'b0) begin
            n_err++; $display("FAIL ll_flush_comb: llbit_o=%b expected 0", llbit_o);
        end
        tick();
        flush = 0; llbit_we = 0; llbit_value = 0;
        #1;
        n_checks++;
        if (llbit_o !== 1'b0) begin
            n_err++; $display("FAIL ll_flush_reg: llbit_o=%b expected 0", llbit_o);
        end
        idle_inputs();
    endtask

    task automatic test_trace();
        logic [31:0] c0;
        logic        t_we   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  t_addr [4] = '{5'd1, 5'd2, 5'd0, 5'd3};
        logic [31:0] t_pc   [4] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0008};
        logic [3:0]  t_wen  [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
        c0 = m_cnt;
        for (int i = 0; i < 4; i++) begin
            we = t_we[i]; waddr = t_addr[i]; wdata = 32'hC0DE_0000 + i; wb_pc = t_pc[i];
            tick();
            n_checks++;
            if (debug_wb_rf_wen !== t_wen[i] || debug_wb_pc !== t_pc[i] ||
                debug_wb_rf_wnum !== t_addr[i] || debug_wb_rf_wdata !== 32'hC0DE_0000 + i) begin
                n_err++; $display("FAIL trace_%0d: wen=%h pc=%h wnum=%0d wdata=%h expected %h %h %0d %h",
                                  i, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata,
                                  t_wen[i], t_pc[i], t_addr[i], 32'hC0DE_0000 + i);
            end
        end
        n_checks++;
        if (wr_cnt !== c0 + 32'd2) begin
            n_err++; $display("FAIL trace_cnt: wr_cnt=%0d expected %0d", wr_cnt, c0 + 32'd2);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        el;
        for (int it = 0; it < 400; it++) begin
            we          = 1'($urandom_range(0, 1));
            waddr       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wdata       = $urandom;
            re1         = ($urandom_range(0, 7) != 0);
            raddr1      = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            re2         = ($urandom_range(0, 7) != 0);
            raddr2      = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            whilo       = 1'($urandom_range(0, 1));
            hi_i        = $urandom;
            lo_i        = $urandom;
            llbit_we    = 1'($urandom_range(0, 1));
            llbit_value = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 7) == 0);
            wb_pc       = 32'hBFC0_1000 + 32'(it * 4);
            #1;
            e1 = exp_read(re1, raddr1);
            e2 = exp_read(re2, raddr2);
            el = exp_ll();
            n_checks++;
            if (rdata1 !== e1 || rdata2 !== e2 || llbit_o !== el) begin
                n_err++; $display("FAIL rand_comb_%0d: rd1=%h rd2=%h ll=%b expected %h %h %b",
                                  it, rdata1, rdata2, llbit_o, e1, e2, el);
            end
            tick();
            n_checks++;
            if (hi_o !== m_hi || lo_o !== m_lo || wr_cnt !== m_cnt || debug_wb_pc !== m_tr_pc ||
                debug_wb_rf_wen !== m_tr_wen || debug_wb_rf_wnum !== m_tr_wnum || debug_wb_rf_wdata !== m_tr_wdata) begin
                n_err++; $display("FAIL rand_reg_%0d: hi=%h lo=%h cnt=%0d pc=%h wen=%h wnum=%0d wd=%h expected %h %h %0d %h %h %0d %h",
                                  it, hi_o, lo_o, wr_cnt, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
                                  m_hi, m_lo, m_cnt, m_tr_pc, m_tr_wen, m_tr_wnum, m_tr_wdata);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        we = 1; waddr = 5'd5; wdata = 32'h5555_AAAA;
        whilo = 1; hi_i = 32'h1; lo_i = 32'h2;
        llbit_we = 1; llbit_value = 1; wb_pc = 32'hBFC0_2000;
        tick();
        idle_inputs();
        re1 = 1; raddr1 = 5'd5;
        #1;
        n_checks++;
        if (rdata1 !== 32'h5555_AAAA || llbit_o !== 1'b1 || wr_cnt === 32'd0) begin
            n_err++; $display("FAIL pre_reset: rdata1=%h ll=%b cnt=%0d expected 5555aaaa 1 nonzero", rdata1, llbit_o, wr_cnt);
        end
        #1 rst = 1;
        #1;
        n_checks++;
        if (rdata1 !== 32'd0 || hi_o !== 32'd0 || lo_o !== 32'd0 || llbit_o !== 1'b0 || wr_cnt !== 32'd0 ||
            debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0) begin
            n_err++; $display("FAIL async_reset: rd1=%h hi=%h lo=%h ll=%b cnt=%0d pc=%h wen=%h expected 0",
                              rdata1, hi_o, lo_o, llbit_o, wr_cnt, debug_wb_pc, debug_wb_rf_wen);
        end
        // A write presented while reset is still high at the edge must not land.
        re1 = 0;
        we = 1; waddr = 5'd3; wdata = 32'h3333_3333; whilo = 1; hi_i = 32'h9;
        tick();
        rst = 0;
        idle_inputs();
        re1 = 1; raddr1 = 5'd3;
        #1;
        n_checks++;
        if (rdata1 !== 32'd0 || hi_o !== 32'd0 || wr_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_edge_write: rd1=%h hi=%h cnt=%0d expected 0", rdata1, hi_o, wr_cnt);
        end
        we = 1; waddr = 5'd3; wdata = 32'h3333_3333;
        tick();
        we = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h3333_3333 || wr_cnt !== 32'd1) begin
            n_err++; $display("FAIL post_reset_write: rd1=%h cnt=%0d expected 33333333 1", rdata1, wr_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        wb_pc = 0;
        rst = 1;
        #12;
        test_reset();
        rst = 0;
        @(posedge clk);
        #1;
        test_write_read();
        test_bypass();
        test_hilo();
        test_llbit();
        test_trace();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
